reg_access_arbiter: RTL and testbench

Shares the tone generator's single-port 32×16 register RAM between two requesters: the synthesis engine, which reads channel registers on a fixed real-time schedule, and the SPI command path, which delivers decoded (address, data, valid) writes. Engine reads always win. SPI writes are buffered in a small FIFO and committed to RAM only on cycles with no engine read. The block sits between the SPI decoder output and the register RAM, next to the channel sequencer.

---
 rtl/reg_access_arbiter.sv | 138 +++++++++++++
 tb/tb_reg_access_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_access_arbiter.sv
// Arbitrates the single-port register RAM between engine reads (always first)
// and buffered SPI writes, which commit in arrival order on read-free cycles.
module reg_access_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 16
) (
  input  logic                              clk_in,
  input  logic                              reset_in,
  input  logic [ADDR_W-1:0]                 wr_addr_in,
  input  logic [DATA_W-1:0]                 wr_data_in,
  input  logic                              wr_valid_in,
  input  logic                              rd_req_in,
  input  logic [ADDR_W-1:0]                 rd_addr_in,
  output logic [DATA_W-1:0]                 rd_data_out,
  output logic                              rd_valid_out,
  output logic [ADDR_W-1:0]                 ram_addr_out,
  output logic [DATA_W-1:0]                 ram_wdata_out,
  output logic                              ram_we_out,
  output logic                              ram_re_out,
  input  logic [DATA_W-1:0]                 ram_rdata_in,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level_out,
  output logic                              overflow_out,
  input  logic                              overflow_clr_in
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  wr_entry_t         fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              ram_re_q, ram_re_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              rd_pipe_q, rd_pipe_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic      empty_c, full_c, pop_c, push_c, drop_c;
  wr_entry_t head_c;

  always_comb begin
    empty_c = (level_q == '0);
    full_c  = (level_q == LVL_W'(FIFO_DEPTH));
    head_c  = fifo_q[rd_ptr_q];
    pop_c   = !rd_req_in && !empty_c;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push_c  = wr_valid_in && (!full_c || pop_c);
    drop_c  = wr_valid_in && full_c && !pop_c;
  end

  always_comb begin
    ram_re_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;

    if (rd_req_in) begin
      ram_re_d   = 1'b1;
      ram_addr_d = rd_addr_in;
    end else if (pop_c) begin
      ram_we_d    = 1'b1;
      ram_addr_d  = head_c.addr;
      ram_wdata_d = head_c.data;
    end

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    overflow_d = drop_c || (overflow_q && !overflow_clr_in);

    // RAM data arrives the cycle after the read strobe, hence one shadow stage.
    rd_pipe_d  = ram_re_q;
    rd_valid_d = rd_pipe_q;
    rd_data_d  = rd_pipe_q ? ram_rdata_in : rd_data_q;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      ram_re_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rd_pipe_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      ram_re_q    <= ram_re_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rd_pipe_q   <= rd_pipe_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Entry storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_in) begin
    if (push_c) fifo_q[wr_ptr_q] <= '{addr: wr_addr_in, data: wr_data_in};
  end

  assign rd_data_out    = rd_data_q;
  assign rd_valid_out   = rd_valid_q;
  assign ram_addr_out   = ram_addr_q;
  assign ram_wdata_out  = ram_wdata_q;
  assign ram_we_out     = ram_we_q;
  assign ram_re_out     = ram_re_q;
  assign fifo_level_out = level_q;
  assign overflow_out   = overflow_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter with a behavioural single-port RAM.
module tb_reg_access_arbiter;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [4:0]  wr_addr_in;
  logic [15:0] wr_data_in;
  logic        wr_valid_in;
  logic        rd_req_in;
  logic [4:0]  rd_addr_in;
  logic [15:0] rd_data_out;
  logic        rd_valid_out;
  logic [4:0]  ram_addr_out;
  logic [15:0] ram_wdata_out;
  logic        ram_we_out;
  logic        ram_re_out;
  logic [15:0] ram_rdata_in;
  logic [2:0]  fifo_level_out;
  logic        overflow_out;
  logic        overflow_clr_in;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [15:0] ram_mem [32];

  reg_access_arbiter #(.FIFO_DEPTH(4), .ADDR_W(5), .DATA_W(16)) dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .wr_addr_in      (wr_addr_in),
    .wr_data_in      (wr_data_in),
    .wr_valid_in     (wr_valid_in),
    .rd_req_in       (rd_req_in),
    .rd_addr_in      (rd_addr_in),
    .rd_data_out     (rd_data_out),
    .rd_valid_out    (rd_valid_out),
    .ram_addr_out    (ram_addr_out),
    .ram_wdata_out   (ram_wdata_out),
    .ram_we_out      (ram_we_out),
    .ram_re_out      (ram_re_out),
    .ram_rdata_in    (ram_rdata_in),
    .fifo_level_out  (fifo_level_out),
    .overflow_out    (overflow_out),
    .overflow_clr_in (overflow_clr_in)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous RAM: read data is valid the cycle after the read strobe.
  always @(posedge clk_in) begin
    if (ram_we_out) ram_mem[ram_addr_out] <= ram_wdata_out;
    if (ram_re_out) ram_rdata_in <= ram_mem[ram_addr_out];
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_write(input string tag, input logic [4:0] addr, input logic [15:0] data);
    check({tag, "_we"},    32'(ram_we_out),    32'd1);
    check({tag, "_re"},    32'(ram_re_out),    32'd0);
    check({tag, "_addr"},  32'(ram_addr_out),  32'(addr));
    check({tag, "_wdata"}, 32'(ram_wdata_out), 32'(data));
  endtask

  initial begin
    reset_in        = 1'b1;
    wr_addr_in      = '0;
    wr_data_in      = '0;
    wr_valid_in     = 1'b0;
    rd_req_in       = 1'b0;
    rd_addr_in      = '0;
    overflow_clr_in = 1'b0;
    ram_rdata_in    = '0;
    for (int i = 0; i < 32; i++) ram_mem[i] = 16'h0;

    // Reset values
    tick();
    tick();
    reset_in = 1'b0;
    check("rst_re",    32'(ram_re_out),     32'd0);
    check("rst_we",    32'(ram_we_out),     32'd0);
    check("rst_addr",  32'(ram_addr_out),   32'd0);
    check("rst_wdata", 32'(ram_wdata_out),  32'd0);
    check("rst_rv",    32'(rd_valid_out),   32'd0);
    check("rst_rdata", 32'(rd_data_out),    32'd0);
    check("rst_level", 32'(fifo_level_out), 32'd0);
    check("rst_ovf",   32'(overflow_out),   32'd0);

    // Read and push in flight, then asynchronous reset mid-stream
    rd_req_in = 1'b1; rd_addr_in = 5'd5;
    wr_valid_in = 1'b1; wr_addr_in = 5'd1; wr_data_in = 16'h1234;
    tick();
    check("pre_rst_re",    32'(ram_re_out),     32'd1);
    check("pre_rst_level", 32'(fifo_level_out), 32'd1);
    rd_req_in = 1'b0; wr_valid_in = 1'b0;
    reset_in = 1'b1;
    #1;
    check("mid_rst_re",    32'(ram_re_out),     32'd0);
    check("mid_rst_level", 32'(fifo_level_out), 32'd0);
    check("mid_rst_addr",  32'(ram_addr_out),   32'd0);
    tick();
    tick();
    reset_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_rv", 32'(rd_valid_out), 32'd0);
      check("post_rst_we", 32'(ram_we_out),   32'd0);
    end

    // Single write then read
    wr_valid_in = 1'b1; wr_addr_in = 5'h03; wr_data_in = 16'hA5C3;
    tick();
    wr_valid_in = 1'b0;
    check("w1_level", 32'(fifo_level_out), 32'd1);
    check("w1_we0",   32'(ram_we_out),     32'd0);
    tick();
    check_write("w1_commit", 5'h03, 16'hA5C3);
    check("w1_level0", 32'(fifo_level_out), 32'd0);
    tick();
    check("w1_we_off", 32'(ram_we_out), 32'd0);
    rd_req_in = 1'b1; rd_addr_in = 5'h03;
    tick();
    rd_req_in = 1'b0;
    check("r1_re",   32'(ram_re_out),   32'd1);
    check("r1_addr", 32'(ram_addr_out), 32'd3);
    check("r1_we",   32'(ram_we_out),   32'd0);
    tick();
    check("r1_rv_early", 32'(rd_valid_out), 32'd0);
    tick();
    check("r1_rv",    32'(rd_valid_out), 32'd1);
    check("r1_rdata", 32'(rd_data_out),  32'hA5C3);
    tick();
    check("r1_rv_off",  32'(rd_valid_out), 32'd0);
    check("r1_rd_hold", 32'(rd_data_out),  32'hA5C3);

    // Read priority: writes stall while reads are continuous
    rd_req_in = 1'b1; rd_addr_in = 5'h03;
    for (int i = 0; i < 6; i++) begin
      wr_valid_in = (i < 3);
      wr_addr_in  = (i == 1) ? 5'd11 : 5'd10;
      wr_data_in  = (i == 0) ? 16'h1111 : (i == 1) ? 16'h2222 : 16'h3333;
      tick();
      check("prio_we0", 32'(ram_we_out), 32'd0);
      check("prio_re1", 32'(ram_re_out), 32'd1);
    end
    wr_valid_in = 1'b0;
    check("prio_level3", 32'(fifo_level_out), 32'd3);
    rd_req_in = 1'b0;
    tick();
    check_write("prio_c0", 5'd10, 16'h1111);
    tick();
    check_write("prio_c1", 5'd11, 16'h2222);
    tick();
    check_write("prio_c2", 5'd10, 16'h3333);
    tick();
    check("prio_we_off", 32'(ram_we_out),     32'd0);
    check("prio_level0", 32'(fifo_level_out), 32'd0);
    rd_req_in = 1'b1; rd_addr_in = 5'd10;
    tick();
    rd_req_in = 1'b0;
    tick();
    tick();
    check("prio_rv",   32'(rd_valid_out), 32'd1);
    check("prio_last", 32'(rd_data_out),  32'h3333);

    // Overflow with reads held; clear-vs-set on the same edge
    rd_req_in = 1'b1; rd_addr_in = 5'd0;
    for (int k = 0; k < 5; k++) begin
      wr_valid_in = 1'b1; wr_addr_in = 5'd20; wr_data_in = 16'hA000 + 16'(k);
      tick();
      check("ovf_level", 32'(fifo_level_out), (k < 4) ? 32'(k + 1) : 32'd4);
      check("ovf_flag",  32'(overflow_out),   (k == 4) ? 32'd1 : 32'd0);
    end
    wr_data_in = 16'hA005; overflow_clr_in = 1'b1;
    tick();
    check("ovf_set_wins", 32'(overflow_out),   32'd1);
    check("ovf_level4",   32'(fifo_level_out), 32'd4);
    wr_valid_in = 1'b0;
    tick();
    overflow_clr_in = 1'b0;
    check("ovf_clr", 32'(overflow_out), 32'd0);

    // Full FIFO with push and pop on the same edge
    rd_req_in = 1'b0;
    wr_valid_in = 1'b1; wr_addr_in = 5'd21; wr_data_in = 16'hBEEF;
    tick();
    wr_valid_in = 1'b0;
    check("full_pp_level", 32'(fifo_level_out), 32'd4);
    check("full_pp_ovf",   32'(overflow_out),   32'd0);
    check_write("full_c0", 5'd20, 16'hA000);
    for (int j = 0; j < 4; j++) begin
      tick();
      check_write("full_cn", (j < 3) ? 5'd20 : 5'd21, (j < 3) ? 16'hA001 + 16'(j) : 16'hBEEF);
    end
    tick();
    check("full_drain_we",    32'(ram_we_out),     32'd0);
    check("full_drain_level", 32'(fifo_level_out), 32'd0);

    // Preload addresses 0..7 through the write path
    for (int i = 0; i < 8; i++) begin
      wr_valid_in = 1'b1; wr_addr_in = 5'(i); wr_data_in = 16'hC000 + 16'(i);
      tick();
    end
    wr_valid_in = 1'b0;
    tick();
    tick();
    check("pre_level0", 32'(fifo_level_out), 32'd0);

    // Back-to-back reads of addresses 0..7
    for (int c = 0; c < 11; c++) begin
      rd_req_in  = (c < 8);
      rd_addr_in = 5'(c);
      tick();
      if (c >= 2 && c < 10) begin
        check("b2b_rv",    32'(rd_valid_out), 32'd1);
        check("b2b_rdata", 32'(rd_data_out),  32'hC000 + 32'(c - 2));
      end else begin
        check("b2b_rv_idle", 32'(rd_valid_out), 32'd0);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
